ram_dma: RTL and testbench

Initiator-side engine for the single-port 8-bit on-chip RAM: it drives the RAM's `we`/`addr`/`di` and consumes its `do` to perform block FILL, COPY and COMPARE operations on command. It sits between the control logic (CPU/sequencer) and one RAM instance, and owns that RAM port exclusively while busy. It is the other end of the RAM protocol: the address is registered by the RAM at the clock edge, and read data appears on `do` during the following cycle.

---
 rtl/ram_pkg.sv | 21 ++
 rtl/ram_dma.sv | 129 ++++++++++++
 tb/tb_ram_dma.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the on-chip byte RAM and its DMA initiator.
package ram_pkg;

  localparam int RAM_ADDR_BITS = 13;

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_CMP  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_C_RD,
    ST_C_WR,
    ST_K_SRC,
    ST_K_DST,
    ST_K_LAST,
    ST_FIN
  } dma_state_t;

endpackage

// File: rtl/ram_dma.sv
// Block FILL / COPY / COMPARE engine driving one single-port byte RAM.
// FILL: 1 byte/cycle; COPY and CMP: 2 cycles/byte; no backpressure, owns the RAM port while busy.
module ram_dma
  import ram_pkg::*;
#(
  parameter int ADDR_BITS = RAM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [ADDR_BITS-1:0] src,
  input  logic [ADDR_BITS-1:0] dst,
  input  logic [ADDR_BITS:0]   len,
  input  logic [7:0]           fill_val,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_BITS-1:0] mis_off,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  input  logic [7:0]           ram_do
);

  dma_state_t state, state_nxt;

  logic [ADDR_BITS-1:0] src_q, dst_q;
  logic [ADDR_BITS:0]   len_q, i_q, i_nxt;
  logic [ADDR_BITS-1:0] i_a, mis_nxt;
  logic [7:0]           fill_q, hold_q;
  logic                 last, mism;

  assign i_nxt   = i_q + 1'b1;
  assign i_a     = i_q[ADDR_BITS-1:0];
  assign mis_nxt = i_a - 1'b1;
  assign last    = (i_nxt == len_q);
  assign mism    = (ram_do != hold_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0 || op == 2'd3) state_nxt = ST_FIN;
          else if (op == OP_FILL)      state_nxt = ST_FILL;
          else if (op == OP_COPY)      state_nxt = ST_C_RD;
          else                         state_nxt = ST_K_SRC;
        end
      end
      ST_FILL:   if (last) state_nxt = ST_FIN;
      ST_C_RD:   state_nxt = ST_C_WR;
      ST_C_WR:   state_nxt = last ? ST_FIN : ST_C_RD;
      // At i>0 ram_do carries dst byte i-1, read during the previous K_DST.
      ST_K_SRC:  state_nxt = (i_q != '0 && mism) ? ST_FIN : ST_K_DST;
      ST_K_DST:  state_nxt = last ? ST_K_LAST : ST_K_SRC;
      ST_K_LAST: state_nxt = ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    case (state)
      ST_FILL: begin
        busy = 1'b1; ram_we = 1'b1; ram_addr = dst_q + i_a; ram_di = fill_q;
      end
      ST_C_RD:   begin busy = 1'b1; ram_addr = src_q + i_a; end
      ST_C_WR: begin
        busy = 1'b1; ram_we = 1'b1; ram_addr = dst_q + i_a; ram_di = ram_do;
      end
      ST_K_SRC:  begin busy = 1'b1; ram_addr = src_q + i_a; end
      ST_K_DST:  begin busy = 1'b1; ram_addr = dst_q + i_a; end
      ST_K_LAST: busy = 1'b1;
      ST_FIN:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      err     <= 1'b0;
      mis_off <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          src_q   <= src;
          dst_q   <= dst;
          len_q   <= len;
          fill_q  <= fill_val;
          i_q     <= '0;
          err     <= (op == 2'd3);
          mis_off <= '0;
        end
        ST_FILL, ST_C_WR: i_q <= i_nxt;
        ST_K_SRC: if (i_q != '0 && mism) begin
          err     <= 1'b1;
          mis_off <= mis_nxt;
        end
        ST_K_DST: begin
          hold_q <= ram_do;
          i_q    <= i_nxt;
        end
        ST_K_LAST: if (mism) begin
          err     <= 1'b1;
          mis_off <= mis_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma with a behavioural single-port RAM; a monitor scores every done pulse.
module tb_ram_dma;
  import ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [12:0] src = '0, dst = '0;
  logic [13:0] len = '0;
  logic [7:0]  fill_val = '0;
  logic        busy, done, err, ram_we;
  logic [12:0] mis_off, ram_addr;
  logic [7:0]  ram_di, ram_do;

  ram_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
    .mis_off(mis_off), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  // RAM model: address registered at the edge, data on do the following cycle.
  logic [7:0]  mem [0:8191];
  logic [12:0] addr_q = '0;
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [7:0]  bd_di = '0;
  always @(posedge clk) begin
    if (bd_we)       mem[bd_addr] <= bd_di;
    else if (ram_we) mem[ram_addr] <= ram_di;
    addr_q <= ram_addr;
  end
  assign ram_do = mem[addr_q];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [12:0] mis;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_bad = 0;
  int done_cnt = 0, we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_err", 32'(err), 32'(e.err));
        if (e.err && e.mis != '0 || !e.err) chk("mis_off", 32'(mis_off), 32'(e.mis));
      end
    end
  end

  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_di = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [12:0] s, input logic [12:0] d,
                       input logic [13:0] n, input logic [7:0] fv, input bit expect_done,
                       input int rel, input logic e_err, input logic [12:0] e_mis);
    exp_t e;
    @(negedge clk);
    op = o; src = s; dst = d; len = n; fill_val = fv; start = 1'b1;
    if (expect_done) begin
      e.cyc = cyc + rel; e.err = e_err; e.mis = e_mis;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 100 && !done; k++) @(negedge clk);
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int w0, d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mis", 32'(mis_off), 0);
    chk("rst_ram", {ram_we, ram_addr, ram_di}, 0);
    rst_n = 1'b1;

    // FILL 0x100..0x103 with A5; 0x104 must survive.
    poke(13'h104, 8'h5C);
    issue(OP_FILL, 13'h0, 13'h100, 14'd4, 8'hA5, 1'b1, 5, 1'b0, 13'h0);
    wait_done("fill");
    for (int a = 'h100; a < 'h104; a++) chk("fill_byte", 32'(mem[a]), 32'hA5);
    chk("fill_guard", 32'(mem[13'h104]), 32'h5C);

    // COPY 3 bytes from 0x000 to 0x200.
    poke(13'h000, 8'h11); poke(13'h001, 8'h22); poke(13'h002, 8'h33);
    issue(OP_COPY, 13'h000, 13'h200, 14'd3, 8'h00, 1'b1, 7, 1'b0, 13'h0);
    wait_done("copy");
    chk("copy_0", 32'(mem[13'h200]), 32'h11);
    chk("copy_1", 32'(mem[13'h201]), 32'h22);
    chk("copy_2", 32'(mem[13'h202]), 32'h33);

    // CMP equal 8-byte regions, then with byte 5 corrupted.
    for (int k = 0; k < 8; k++) begin
      poke(13'(32'h300 + k), 8'(8'h40 + k));
      poke(13'(32'h400 + k), 8'(8'h40 + k));
    end
    issue(OP_CMP, 13'h300, 13'h400, 14'd8, 8'h00, 1'b1, 18, 1'b0, 13'h0);
    wait_done("cmp_pass");
    poke(13'h405, 8'hFF);
    issue(OP_CMP, 13'h300, 13'h400, 14'd8, 8'h00, 1'b1, 14, 1'b1, 13'd5);
    wait_done("cmp_fail");
    chk("cmp_mis_off", 32'(mis_off), 32'd5);

    // FILL wrapping past the top of memory.
    poke(13'h1FFD, 8'h66); poke(13'h0002, 8'h77);
    issue(OP_FILL, 13'h0, 13'h1FFE, 14'd4, 8'h3C, 1'b1, 5, 1'b0, 13'h0);
    wait_done("wrap");
    chk("wrap_1ffe", 32'(mem[13'h1FFE]), 32'h3C);
    chk("wrap_1fff", 32'(mem[13'h1FFF]), 32'h3C);
    chk("wrap_0000", 32'(mem[13'h0000]), 32'h3C);
    chk("wrap_0001", 32'(mem[13'h0001]), 32'h3C);
    chk("wrap_guard_lo", 32'(mem[13'h0002]), 32'h77);
    chk("wrap_guard_hi", 32'(mem[13'h1FFD]), 32'h66);

    // len=0: immediate done, no writes.
    w0 = we_cnt;
    issue(OP_FILL, 13'h0, 13'h1FFE, 14'd0, 8'hEE, 1'b1, 1, 1'b0, 13'h0);
    wait_done("len0");
    chk("len0_no_we", 32'(we_cnt), 32'(w0));
    chk("len0_mem", 32'(mem[13'h1FFE]), 32'h3C);

    // Illegal op: immediate done with err, err held afterwards.
    issue(2'd3, 13'h0, 13'h0, 14'd4, 8'h00, 1'b1, 1, 1'b1, 13'h0);
    wait_done("illegal");
    repeat (2) @(negedge clk);
    chk("illegal_err_held", 32'(err), 1);

    // start pulsed mid-COPY is ignored.
    issue(OP_COPY, 13'h300, 13'h500, 14'd4, 8'h00, 1'b1, 9, 1'b0, 13'h0);
    @(negedge clk);
    op = OP_FILL; dst = 13'h500; len = 14'd1; fill_val = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midcopy_busy", 32'(busy), 1);
    wait_done("midcopy");
    for (int k = 0; k < 4; k++) chk("midcopy_byte", 32'(mem[13'(32'h500 + k)]), 32'(8'h40 + k));

    // Reset during FILL len=8: two bytes written, no done.
    for (int k = 0; k < 8; k++) poke(13'(32'h600 + k), 8'h00);
    d0 = done_cnt;
    issue(OP_FILL, 13'h0, 13'h600, 14'd8, 8'hEE, 1'b0, 0, 1'b0, 13'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {busy, done, err, mis_off, ram_we, ram_addr, ram_di}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    chk("midrst_b0", 32'(mem[13'h600]), 32'hEE);
    chk("midrst_b1", 32'(mem[13'h601]), 32'hEE);
    for (int k = 2; k < 8; k++) chk("midrst_untouched", 32'(mem[13'(32'h600 + k)]), 0);
    chk("pending_expect", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
